// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NONE = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10
  } booth_op_e;

  // Booth recoding of the pair {Q[0], q-1}; 00 and 11 both mean "no operation".
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute-stage issue logic and the multdiv unit.
interface multdiv_if;
  import multdiv_pkg::*;

  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             result_rdy;
  logic             exception;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, operand_a, operand_b,
    input  result, result_rdy, exception, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, operand_a, operand_b,
    output result, result_rdy, exception, busy
  );

endinterface

// File: rtl/multdiv_ctr.sv
// Iteration counter: synchronous clear, count enable, terminal count on the last step.
module multdiv_ctr
  import multdiv_pkg::*;
(
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = en_i ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit, fixed 33-cycle latency.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic      clk,
  input  logic      clr,
  multdiv_if.slave  bus
);

  state_e           state_q, state_d;
  logic             start_mult, start_div, start;
  logic             iter, tc, fin_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, qr_q, result_q;
  logic             qm1_q, exc_q;
  logic [WIDTH-1:0] acc_d, qr_d, abs_a_in, abs_b, res_fin;
  logic             qm1_d, exc_fin;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic             sub;
  booth_op_e        bop;

  assign start_mult = bus.ctrl_mult;
  assign start_div  = bus.ctrl_div & ~bus.ctrl_mult;
  assign start      = start_mult | start_div;

  // One extra cycle after the last step (fin_q) produces the signed/exception result.
  assign iter = ((state_q == S_MULT) || (state_q == S_DIV)) && !fin_q;

  multdiv_ctr u_ctr (
    .clk   (clk),
    .clr_i (clr | start),
    .en_i  (iter),
    .tc_o  (tc)
  );

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_mult)     state_d = S_MULT;
    else if (start_div) state_d = S_DIV;
    else begin
      case (state_q)
        S_MULT, S_DIV: if (fin_q) state_d = S_DONE;
        S_DONE:        state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.result_rdy = (state_q == S_DONE);
    bus.busy       = (state_q != S_IDLE);
  end

  assign bus.result    = result_q;
  assign bus.exception = exc_q;

  assign abs_a_in = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
  assign bop      = booth_decode(qr_q[0], qm1_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    add_a = '0;
    add_b = '0;
    sub   = 1'b0;
    if (state_q == S_MULT) begin
      add_a = {acc_q[WIDTH-1], acc_q};
      add_b = (bop == BOOTH_NONE) ? '0 : {a_q[WIDTH-1], a_q};
      sub   = (bop == BOOTH_SUB);
    end else begin
      add_a = {acc_q, qr_q[WIDTH-1]};
      add_b = {1'b0, abs_b};
      sub   = 1'b1;
    end
    sum = sub ? add_a - add_b : add_a + add_b;
  end

  // Booth keeps the 33-bit sum so the arithmetic shift sees the true sign after overflow.
  always_comb begin
    qm1_d = qr_q[0];
    if (state_q == S_MULT) begin
      acc_d = sum[WIDTH:1];
      qr_d  = {sum[0], qr_q[WIDTH-1:1]};
    end else if (!sum[WIDTH]) begin
      acc_d = sum[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = add_a[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_fin = qr_q;
    exc_fin = 1'b0;
    if (state_q == S_MULT) begin
      exc_fin = !((&{acc_q, qr_q[WIDTH-1]}) || !(|{acc_q, qr_q[WIDTH-1]}));
    end else if (b_q == '0) begin
      res_fin = '0;
      exc_fin = 1'b1;
    end else if ((a_q == INT_MIN) && (&b_q)) begin
      res_fin = INT_MIN;
      exc_fin = 1'b1;
    end else if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
      res_fin = -qr_q;
    end
  end

  // NOTE: sequential state uses <= only, so every register samples pre-edge values of the others.
  // NOTE: the operand latches are reset too; cheap at this size and keeps post-clr state fully defined.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      qm1_q    <= 1'b0;
      fin_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (start) begin
      a_q   <= bus.operand_a;
      b_q   <= bus.operand_b;
      acc_q <= '0;
      qr_q  <= start_mult ? bus.operand_b : abs_a_in;
      qm1_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (iter) begin
      acc_q <= acc_d;
      qr_q  <= qr_d;
      qm1_q <= qm1_d;
      fin_q <= tc;
    end else if (fin_q) begin
      result_q <= res_fin;
      exc_q    <= exc_fin;
      fin_q    <= 1'b0;
    end
  end

endmodule
